// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and widths for the fetch/data memory port arbiter.
//   state_t : arbiter FSM state (idle, or one access outstanding)
//   owner_t : which pipeline stage owns the outstanding access
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (f_*) and the
//   load/store stage (d_*). One access is outstanding at a time; the memory
//   returns read data MEM_LAT cycles after its command. Data wins arbitration
//   unless fetch has watched STARVE_MAX consecutive data grants, in which case
//   fetch is forced through. f_flush discards an in-flight fetch's ack.
//
//   Ports
//     clock, reset                : clock, synchronous active-low reset
//     f_req/f_addr/f_flush        : fetch request, address, squash
//     f_gnt/f_ack/f_rdata/f_stall : fetch grant, data valid, data, stall
//     d_req/d_we/d_addr/d_wdata   : data request, store flag, address, data
//     d_gnt/d_ack/d_rdata/d_stall : data grant, done/valid, load data, stall
//     mem_read/mem_write/mem_addr/mem_wdata/mem_rdata : memory side
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] CNT_INIT   = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_reg, state_next;
  owner_t     owner_reg, owner_next;
  logic [1:0] count_reg, count_next;
  logic [3:0] starve_reg, starve_next;
  logic       flush_reg, flush_next;

  logic complete;
  logic can_issue;
  logic fetch_forced;
  logic issue;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_NONE;
      count_reg  <= '0;
      starve_reg <= '0;
      flush_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      flush_reg  <= flush_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    count_next  = count_reg;
    starve_next = starve_reg;
    flush_next  = flush_reg;

    complete     = (state_reg == ST_BUSY) && (count_reg == 2'd0);
    // Gating with reset keeps every output low while reset is held.
    can_issue    = reset && ((state_reg == ST_IDLE) || complete);
    fetch_forced = f_req && (starve_reg == STARVE_LIM);

    d_gnt = can_issue && d_req && !fetch_forced;
    f_gnt = can_issue && f_req && !d_gnt;
    issue = f_gnt || d_gnt;

    f_stall = reset && f_req && !f_gnt;
    d_stall = reset && d_req && !d_gnt;

    mem_read  = f_gnt || (d_gnt && !d_we);
    mem_write = d_gnt && d_we;
    mem_addr  = f_gnt ? f_addr : (d_gnt ? d_addr : '0);
    mem_wdata = (d_gnt && d_we) ? d_wdata : '0;

    // A flush seen on the completion cycle itself must also squash the ack,
    // hence the live f_flush term alongside the registered flag.
    f_ack   = reset && complete && (owner_reg == OWN_F) && !flush_reg && !f_flush;
    d_ack   = reset && complete && (owner_reg == OWN_D);
    f_rdata = reset ? mem_rdata : '0;
    d_rdata = reset ? mem_rdata : '0;

    if (issue) begin
      state_next = ST_BUSY;
      owner_next = f_gnt ? OWN_F : OWN_D;
      count_next = CNT_INIT;
      flush_next = 1'b0;
    end else if (complete) begin
      state_next = ST_IDLE;
      owner_next = OWN_NONE;
      flush_next = 1'b0;
    end else if (state_reg == ST_BUSY) begin
      count_next = count_reg - 2'd1;
      if ((owner_reg == OWN_F) && f_flush) begin
        flush_next = 1'b1;
      end
    end

    // Counts data grants that fetch had to watch; any fetch grant or a gap
    // in the fetch request starts the count over.
    if (!f_req || f_gnt) begin
      starve_next = '0;
    end else if (d_gnt && (starve_reg != STARVE_LIM)) begin
      starve_next = starve_reg + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic       f_gnt, f_ack, f_stall, d_gnt, d_ack, d_stall, mem_read, mem_write;
  logic [7:0] f_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt), .f_ack(f_ack), .f_rdata(f_rdata), .f_stall(f_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory model: contents plus a small delivery schedule indexed by cycle.
  logic [7:0] memarr  [256];
  logic [7:0] sched_d [4];
  bit         sched_v [4];

  // Reference model: at most one outstanding access, described by its owner,
  // the cycle it completes on, and whether a flush has hit it.
  bit         mv = 0;
  int         m_owner = 0;       // 0 none, 1 fetch, 2 data
  int         m_done = 0;
  bit         m_flushed = 0;
  bit         m_we = 0;
  logic [7:0] m_data = '0;
  int         m_starve = 0;
  bit         comp, e_fg, e_dg, e_fa, e_da;

  typedef struct {
    logic       f_req, d_req, d_we;
    logic [7:0] f_addr, d_addr, d_wdata;
    logic       x_fg, x_dg, x_fs, x_ds, x_mr, x_mw;
    logic [7:0] x_addr, x_wdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%02h want=%02h", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Present memory data for this cycle, then compare every output with the model.
  task automatic cyc_begin();
    bit slot_free, forced;
    if (sched_v[cyc % 4]) begin
      mem_rdata = sched_d[cyc % 4];
      sched_v[cyc % 4] = 1'b0;
    end else begin
      mem_rdata = 8'($urandom);
    end
    #1;
    comp      = mv && (cyc == m_done);
    slot_free = !mv || comp;
    forced    = f_req && (m_starve == STARVE_MAX);
    e_dg = reset && slot_free && d_req && !forced;
    e_fg = reset && slot_free && f_req && !e_dg;
    e_fa = reset && comp && (m_owner == 1) && !m_flushed && !f_flush;
    e_da = reset && comp && (m_owner == 2);

    chk1("f_gnt", f_gnt, e_fg);
    chk1("d_gnt", d_gnt, e_dg);
    chk1("f_stall", f_stall, reset && f_req && !e_fg);
    chk1("d_stall", d_stall, reset && d_req && !e_dg);
    chk1("mem_read", mem_read, e_fg || (e_dg && !d_we));
    chk1("mem_write", mem_write, e_dg && d_we);
    chk1("f_ack", f_ack, e_fa);
    chk1("d_ack", d_ack, e_da);
    if (e_fg || e_dg) chk8("mem_addr", mem_addr, e_fg ? f_addr : d_addr);
    if (e_dg && d_we) chk8("mem_wdata", mem_wdata, d_wdata);
    if (e_fa) chk8("f_rdata", f_rdata, m_data);
    if (e_da && !m_we) chk8("d_rdata", d_rdata, m_data);
    if (!reset) begin
      chk8("rst_f_rdata", f_rdata, 8'h00);
      chk8("rst_d_rdata", d_rdata, 8'h00);
      chk8("rst_mem_addr", mem_addr, 8'h00);
      chk8("rst_mem_wdata", mem_wdata, 8'h00);
    end
  endtask

  // Advance the model and the memory to the next clock edge.
  task automatic cyc_end();
    logic [7:0] a;
    if (!reset) begin
      mv = 0;
      m_owner = 0;
      m_starve = 0;
    end else begin
      if (e_fa) $display("txn cyc=%0d fetch ack data=%02h", cyc, m_data);
      if (e_da) $display("txn cyc=%0d data %s ack data=%02h", cyc, m_we ? "store" : "load", m_data);
      if (mv && (m_owner == 1) && f_flush) m_flushed = 1;
      if (e_fg || e_dg) begin
        a         = e_fg ? f_addr : d_addr;
        mv        = 1;
        m_owner   = e_fg ? 1 : 2;
        m_done    = cyc + MEM_LAT;
        m_flushed = 0;
        m_we      = e_dg && d_we;
        m_data    = memarr[a];
      end else if (comp) begin
        mv = 0;
        m_owner = 0;
      end
      if (!f_req || e_fg) m_starve = 0;
      else if (e_dg && (m_starve < STARVE_MAX)) m_starve++;
    end
    if (mem_read) begin
      sched_d[(cyc + MEM_LAT) % 4] = memarr[mem_addr];
      sched_v[(cyc + MEM_LAT) % 4] = 1'b1;
    end
    if (mem_write) memarr[mem_addr] = mem_wdata;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic idle_inputs();
    f_req = 0; d_req = 0; d_we = 0; f_flush = 0;
  endtask

  initial begin
    int k;
    bit f_pend, d_pend;

    for (int i = 0; i < 256; i++) memarr[i] = 8'($urandom);
    memarr[8'h10] = 8'h5A;
    for (int i = 0; i < 4; i++) sched_v[i] = 1'b0;

    //              f  d  we f_a    d_a    wd     fg dg fs ds mr mw addr   wdata
    vecs[0] = '{1'b0,1'b0,1'b0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
    vecs[1] = '{1'b1,1'b0,1'b0,8'h05,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h05,8'h00};
    vecs[2] = '{1'b0,1'b1,1'b0,8'h00,8'h10,8'h00, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h10,8'h00};
    vecs[3] = '{1'b0,1'b1,1'b1,8'h00,8'h20,8'h33, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h20,8'h33};
    vecs[4] = '{1'b1,1'b1,1'b0,8'h07,8'h40,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'h40,8'h00};
    vecs[5] = '{1'b1,1'b1,1'b1,8'h07,8'h41,8'h99, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'h41,8'h99};

    @(posedge clock);
    #1;

    // Reset held: every output must stay low.
    f_req = 1; d_req = 1; d_addr = 8'h22; f_addr = 8'h23;
    repeat (2) step();
    idle_inputs();
    reset = 1;
    step();

    // Single-cycle issue decisions from idle.
    for (int i = 0; i < 6; i++) begin
      f_req = vecs[i].f_req; d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      f_addr = vecs[i].f_addr; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      cyc_begin();
      chk1("vec_f_gnt", f_gnt, vecs[i].x_fg);
      chk1("vec_d_gnt", d_gnt, vecs[i].x_dg);
      chk1("vec_f_stall", f_stall, vecs[i].x_fs);
      chk1("vec_d_stall", d_stall, vecs[i].x_ds);
      chk1("vec_mem_read", mem_read, vecs[i].x_mr);
      chk1("vec_mem_write", mem_write, vecs[i].x_mw);
      if (vecs[i].x_fg || vecs[i].x_dg) chk8("vec_mem_addr", mem_addr, vecs[i].x_addr);
      if (vecs[i].x_mw) chk8("vec_mem_wdata", mem_wdata, vecs[i].x_wdata);
      cyc_end();
      idle_inputs();
      repeat (MEM_LAT) step();
    end

    // Load 0x10 alone: ack MEM_LAT cycles after the grant with memory data.
    d_req = 1; d_we = 0; d_addr = 8'h10;
    cyc_begin();
    chk1("ld_gnt", d_gnt, 1'b1);
    chk8("ld_addr", mem_addr, 8'h10);
    cyc_end();
    d_req = 0;
    step();
    cyc_begin();
    chk1("ld_ack", d_ack, 1'b1);
    chk8("ld_data", d_rdata, 8'h5A);
    cyc_end();

    // Store then fetch, fetch issues on the store's completion cycle.
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h33; f_req = 1; f_addr = 8'h05;
    cyc_begin();
    chk1("sf_write", mem_write, 1'b1);
    chk1("sf_fstall0", f_stall, 1'b1);
    cyc_end();
    d_req = 0; d_we = 0;
    cyc_begin();
    chk1("sf_fstall1", f_stall, 1'b1);
    cyc_end();
    cyc_begin();
    chk1("sf_dack", d_ack, 1'b1);
    chk1("sf_fgnt", f_gnt, 1'b1);
    chk8("sf_faddr", mem_addr, 8'h05);
    cyc_end();
    f_req = 0;
    step();
    cyc_begin();
    chk1("sf_fack", f_ack, 1'b1);
    cyc_end();
    f_req = 1; f_addr = 8'h20;
    step();
    f_req = 0;
    step();
    cyc_begin();
    chk8("sf_readback", f_rdata, 8'h33);
    cyc_end();

    // Both requesters held: STARVE_MAX data grants, then one fetch grant.
    f_req = 1; d_req = 1; d_we = 0; d_addr = 8'h30; f_addr = 8'h31;
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      cyc_begin();
      if (f_gnt || d_gnt) begin
        chk1("starve_fgnt", f_gnt, (k % (STARVE_MAX + 1)) == STARVE_MAX);
        k++;
      end else begin
        chk1("starve_fstall", f_stall, 1'b1);
      end
      cyc_end();
    end
    chk32("starve_grants", k, 10);
    idle_inputs();
    repeat (MEM_LAT) step();

    // Flush one cycle before completion: no fetch ack, next grant unaffected.
    f_req = 1; f_addr = 8'h08;
    step();
    f_req = 0; f_flush = 1;
    step();
    f_flush = 0; d_req = 1; d_we = 0; d_addr = 8'h11;
    cyc_begin();
    chk1("flush_noack", f_ack, 1'b0);
    chk1("flush_dgnt", d_gnt, 1'b1);
    cyc_end();
    idle_inputs();
    repeat (MEM_LAT) step();

    // Reset mid-access: abandoned load never acks, next request issues at once.
    d_req = 1; d_we = 0; d_addr = 8'h12;
    step();
    d_req = 0; reset = 0;
    step();
    reset = 1; f_req = 1; f_addr = 8'h09;
    cyc_begin();
    chk1("rst_noack", d_ack, 1'b0);
    chk1("rst_fgnt", f_gnt, 1'b1);
    cyc_end();
    idle_inputs();
    repeat (MEM_LAT) step();

    // Random traffic against the reference model.
    f_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!f_pend && ($urandom_range(0, 3) == 0)) begin
        f_pend = 1; f_addr = 8'($urandom);
      end
      if (!d_pend && ($urandom_range(0, 1) == 0)) begin
        d_pend = 1; d_we = 1'($urandom); d_addr = 8'($urandom); d_wdata = 8'($urandom);
      end
      f_req   = f_pend;
      d_req   = d_pend;
      f_flush = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 150) != 0);
      step();
      if (e_fg) f_pend = 0;
      if (e_dg) d_pend = 0;
    end
    reset = 1;
    idle_inputs();
    repeat (MEM_LAT + 1) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
